// File: rtl/rs_pulse_ctrl_pkg.sv
// Shared types and default timing constants for the push-button to NOR-latch pulse driver.
package rs_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_S = 2'd1,
        PULSE_R = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam int DEF_DEBOUNCE = 4;
    localparam int DEF_PULSE    = 3;
    localparam int DEF_GAP      = 2;

endpackage

// File: rtl/rs_pulse_ctrl_if.sv
// Button inputs and latch-drive outputs of rs_pulse_ctrl, plus the FSM state for observation.
interface rs_pulse_ctrl_if;
    import rs_pulse_pkg::*;

    // No valid/ready handshake here: set_btn/clr_btn are raw asynchronous levels, and
    // s/r/busy/conflict/state are level outputs that are meaningful on every clock cycle.
    logic   set_btn;
    logic   clr_btn;
    logic   s;
    logic   r;
    logic   busy;
    logic   conflict;
    state_t state;

    modport master (output set_btn, clr_btn, input s, r, busy, conflict, state);
    modport slave  (input set_btn, clr_btn, output s, r, busy, conflict, state);

endinterface

// File: rtl/rs_pulse_ctrl_debounce_sync.sv
// Two-flop synchronizer, stability-count debouncer and rising-edge detect for one button.
module debounce_sync #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("debounce_sync: DEBOUNCE_CYCLES must be at least 1");
    end

    logic          sync1;
    logic          sync2;
    logic          deb_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            deb   <= 1'b0;
            deb_d <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            // Any cycle where the synchronized level agrees with deb restarts the count.
            if (sync2 != deb) begin
                if (cnt == LAST) begin
                    deb <= sync2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign rise = deb & ~deb_d;

endmodule

// File: rtl/rs_pulse_ctrl.sv
// Arbitrates debounced set/clear presses into non-overlapping, fixed-width s/r pulses for a NOR latch.
module rs_pulse_ctrl
    import rs_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
    parameter int PULSE_WIDTH     = DEF_PULSE,
    parameter int GAP_CYCLES      = DEF_GAP
) (
    input logic            clk,
    input logic            rst,
    rs_pulse_ctrl_if.slave bus
);
    localparam int MAX_CNT = (PULSE_WIDTH > GAP_CYCLES) ? PULSE_WIDTH : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_WIDTH - 1);
    localparam logic [CW-1:0] GAP_LAST   = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
    localparam state_t AFTER_PULSE = (GAP_CYCLES > 0) ? GAP : IDLE;

    if (PULSE_WIDTH < 1) begin : g_bad_pulse
        $error("rs_pulse_ctrl: PULSE_WIDTH must be at least 1");
    end
    if (GAP_CYCLES < 0) begin : g_bad_gap
        $error("rs_pulse_ctrl: GAP_CYCLES must be non-negative");
    end

    state_t        state, state_next;
    logic [CW-1:0] wcnt, wcnt_next;
    logic          conflict_q, conflict_next;
    logic          set_deb, set_rise, clr_deb, clr_rise;

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
        .clk(clk), .rst(rst), .raw(bus.set_btn), .deb(set_deb), .rise(set_rise)
    );

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
        .clk(clk), .rst(rst), .raw(bus.clr_btn), .deb(clr_deb), .rise(clr_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wcnt       <= '0;
            conflict_q <= 1'b0;
        end else begin
            state      <= state_next;
            wcnt       <= wcnt_next;
            conflict_q <= conflict_next;
        end
    end

    always_comb begin
        state_next    = state;
        wcnt_next     = wcnt + CW'(1);
        conflict_next = 1'b0;
        unique case (state)
            IDLE: begin
                wcnt_next = '0;
                // Clear wins a tie so the latch ends in the safe reset state.
                if (clr_rise) begin
                    state_next = PULSE_R;
                end else if (set_rise) begin
                    state_next = PULSE_S;
                end
                conflict_next = set_rise & clr_rise;
            end
            PULSE_S, PULSE_R: begin
                conflict_next = set_rise | clr_rise;
                if (wcnt == PULSE_LAST) begin
                    state_next = AFTER_PULSE;
                end
            end
            GAP: begin
                conflict_next = set_rise | clr_rise;
                if (wcnt == GAP_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (state_next != state) begin
            wcnt_next = '0;
        end
    end

    assign bus.s        = (state == PULSE_S);
    assign bus.r        = (state == PULSE_R);
    assign bus.busy     = (state != IDLE);
    assign bus.conflict = conflict_q;
    assign bus.state    = state;

endmodule

// File: tb/tb_rs_pulse_ctrl.sv
// Directed scenarios plus random button activity, checked every cycle against a schedule-based model.
module tb_rs_pulse_ctrl;
    import rs_pulse_pkg::*;

    localparam int D  = 4;
    localparam int PW = 3;
    localparam int G  = 2;

    logic clk;
    logic rst;
    logic q;
    logic qb;

    rs_pulse_ctrl_if bus();

    rs_pulse_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .PULSE_WIDTH(PW),
        .GAP_CYCLES(G)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Behavioural NOR latch as the load.
    initial q = 1'b0;
    always @(bus.s or bus.r) begin
        if (bus.s) q = 1'b1;
        else if (bus.r) q = 1'b0;
    end
    assign qb = ~q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: raw->sync pipeline, debounce window, and pulse schedule.
    int   e = 0;
    logic m_p1[2];
    logic m_p2[2];
    logic m_deb[2];
    logic m_pend[2];
    logic m_hist[2][D];
    bit   m_active = 1'b0;
    int   m_start  = 0;
    bit   m_kind_r = 1'b0;
    logic m_conf   = 1'b0;
    logic m_q      = 1'b0;

    int cnt_s, cnt_r, cnt_conf, first_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, e);
        end
    endtask

    task automatic model_edge(input logic rst_v, input logic [1:0] raw);
        bit idle;
        bit all_diff;
        if (rst_v) begin
            for (int i = 0; i < 2; i++) begin
                m_p1[i] = 1'b0; m_p2[i] = 1'b0; m_deb[i] = 1'b0; m_pend[i] = 1'b0;
                for (int k = 0; k < D; k++) m_hist[i][k] = 1'b0;
            end
            m_active = 1'b0;
            m_conf   = 1'b0;
        end else begin
            idle   = !m_active || (e > m_start + PW + G);
            m_conf = 1'b0;
            if (m_pend[0] || m_pend[1]) begin
                if (idle) begin
                    m_active = 1'b1;
                    m_start  = e;
                    m_kind_r = m_pend[1];
                    m_conf   = m_pend[0] && m_pend[1];
                end else begin
                    m_conf = 1'b1;
                end
            end
            for (int i = 0; i < 2; i++) begin
                for (int k = D - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
                m_hist[i][0] = m_p2[i];
                all_diff = 1'b1;
                for (int k = 0; k < D; k++) if (m_hist[i][k] == m_deb[i]) all_diff = 1'b0;
                m_pend[i] = 1'b0;
                if (all_diff) begin
                    m_deb[i]  = ~m_deb[i];
                    m_pend[i] = m_deb[i];
                end
                m_p2[i] = m_p1[i];
                m_p1[i] = raw[i];
            end
        end
    endtask

    task automatic step();
        logic       rst_v;
        logic [1:0] raw;
        logic       exp_s, exp_r, exp_b;
        rst_v = rst;
        raw   = {bus.clr_btn, bus.set_btn};
        @(posedge clk);
        #1;
        e++;
        model_edge(rst_v, raw);
        exp_s = m_active && !m_kind_r && (e < m_start + PW);
        exp_r = m_active &&  m_kind_r && (e < m_start + PW);
        exp_b = m_active && (e < m_start + PW + G);
        if (exp_s) m_q = 1'b1;
        else if (exp_r) m_q = 1'b0;
        chk("s", bus.s, exp_s);
        chk("r", bus.r, exp_r);
        chk("busy", bus.busy, exp_b);
        chk("conflict", bus.conflict, m_conf);
        chk("s_and_r", bus.s & bus.r, 1'b0);
        chk("latch_q", q, m_q);
        chk("deb_set", u_dut.u_set_db.deb, m_deb[0]);
        chk("deb_clr", u_dut.u_clr_db.deb, m_deb[1]);
        cnt_s    += int'(bus.s);
        cnt_r    += int'(bus.r);
        cnt_conf += int'(bus.conflict);
        if (bus.s === 1'b1 && first_s < 0) first_s = e;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_counts();
        cnt_s = 0; cnt_r = 0; cnt_conf = 0; first_s = -1;
    endtask

    initial begin
        int e0;
        int n;
        bit seen;
        rst = 1'b1;
        bus.set_btn = 1'b0;
        bus.clr_btn = 1'b0;
        clear_counts();

        // Reset, then a clean set press.
        steps(3);
        chk("reset_state", bus.state, IDLE);
        rst = 1'b0;
        steps(3);
        clear_counts();
        e0 = e;
        bus.set_btn = 1'b1;
        steps(15);
        chk("clean_latency", first_s - e0, D + 3);
        chk("clean_s_cycles", cnt_s, PW);
        chk("clean_r_cycles", cnt_r, 0);
        chk("clean_conflict", cnt_conf, 0);
        chk("clean_q", q, 1'b1);
        chk("clean_qb", qb, 1'b0);
        bus.set_btn = 1'b0;
        steps(12);

        // Bounce shorter than the debounce window.
        clear_counts();
        for (int k = 0; k < 10; k++) begin
            bus.set_btn = ~bus.set_btn;
            steps(2);
        end
        bus.set_btn = 1'b0;
        steps(10);
        chk("bounce_s_cycles", cnt_s, 0);
        chk("bounce_deb", u_dut.u_set_db.deb, 1'b0);

        // Simultaneous press: clear wins, one conflict flag.
        clear_counts();
        bus.set_btn = 1'b1;
        bus.clr_btn = 1'b1;
        steps(16);
        chk("simul_r_cycles", cnt_r, PW);
        chk("simul_s_cycles", cnt_s, 0);
        chk("simul_conflict", cnt_conf, 1);
        chk("simul_q", q, 1'b0);
        bus.set_btn = 1'b0;
        bus.clr_btn = 1'b0;
        steps(12);

        // Set press arriving while the clear pulse is running is dropped.
        clear_counts();
        bus.clr_btn = 1'b1;
        steps(2);
        bus.set_btn = 1'b1;
        steps(16);
        chk("drop_s_cycles", cnt_s, 0);
        chk("drop_r_cycles", cnt_r, PW);
        chk("drop_conflict", cnt_conf, 1);
        bus.set_btn = 1'b0;
        bus.clr_btn = 1'b0;
        steps(12);
        clear_counts();
        bus.set_btn = 1'b1;
        steps(14);
        chk("after_drop_s_cycles", cnt_s, PW);
        chk("after_drop_q", q, 1'b1);
        bus.set_btn = 1'b0;
        steps(12);

        // Reset during the second cycle of an s pulse.
        bus.clr_btn = 1'b1;
        steps(14);
        bus.clr_btn = 1'b0;
        steps(12);
        bus.set_btn = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            seen = (bus.s === 1'b1);
        end
        chk("midpulse_s_seen", seen, 1'b1);
        step();
        rst = 1'b1;
        bus.set_btn = 1'b0;
        step();
        rst = 1'b0;
        chk("midpulse_s_off", bus.s, 1'b0);
        chk("midpulse_busy_off", bus.busy, 1'b0);
        chk("midpulse_state", bus.state, IDLE);
        clear_counts();
        steps(15);
        chk("midpulse_no_stray", cnt_s + cnt_r, 0);

        // One press held for 50 cycles gives exactly one pulse.
        clear_counts();
        bus.set_btn = 1'b1;
        steps(50);
        bus.set_btn = 1'b0;
        steps(12);
        chk("held_s_cycles", cnt_s, PW);
        chk("held_conflict", cnt_conf, 0);

        // Random button activity with occasional resets.
        for (int it = 0; it < 250; it++) begin
            bus.set_btn = 1'($urandom_range(0, 1));
            bus.clr_btn = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 39) == 0);
            n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++) begin
                step();
                rst = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
